simon_core_arbiter: RTL and testbench

- Shares one SIMON cipher core (N-bit words, 2N-bit block) between two independent requesters, e.g. host port and DMA port.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Issues a one-cycle start to the core, waits for the core's done, then routes the result back to the granted requester with a valid/ready response handshake.
- Sits between the requester interfaces and the SIMON control/datapath. The key is loaded separately and is not handled here.

---
 rtl/simon_core_arbiter.sv | 150 +++++++++++++++
 tb/tb_simon_core_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_core_arbiter.sv
// simon_core_arbiter: round-robin sharing of one SIMON cipher core between two requesters.
// Optional WAIT watchdog abort is compiled in when SIMON_ARB_TIMEOUT_EN is defined.
module simon_core_arbiter #(
  parameter int unsigned N    = 16,
  parameter int unsigned TMAX = 255
) (
  input  logic                clk,
  input  logic                nR,
  input  logic [1:0]          reqValid,
  input  logic [1:0]          reqEncDec,
  input  logic [1:0][2*N-1:0] reqBlock,
  output logic [1:0]          reqReady,
  output logic [1:0]          respValid,
  input  logic [1:0]          respReady,
  output logic [2*N-1:0]      respBlock,
  output logic                respErr,
  output logic                coreStart,
  output logic                coreEncDec,
  output logic [2*N-1:0]      coreBlock,
  input  logic                coreDone,
  input  logic [2*N-1:0]      coreResult,
  output logic                busy,
  output logic                grantId
);
  localparam int unsigned BW = 2 * N;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_sel_c;
  logic          wdog_hit_c;
  logic [1:0]    req_ready_d, resp_valid_d;
  logic          core_start_d, core_enc_dec_d, grant_id_d, busy_d;
  logic [BW-1:0] core_block_d, resp_block_d;

  // Both valid: the one not served last; otherwise the single valid requester.
  assign grant_sel_c = (reqValid == 2'b11) ? ~last_grant_q : reqValid[1];

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|reqValid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (coreDone || wdog_hit_c) state_d = S_RESP;
      S_RESP:  if (respReady[grantId]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless the state acts on it.
  always_comb begin
    req_ready_d    = 2'b00;
    core_start_d   = 1'b0;
    core_enc_dec_d = coreEncDec;
    core_block_d   = coreBlock;
    grant_id_d     = grantId;
    resp_valid_d   = respValid;
    resp_block_d   = respBlock;
    last_grant_d   = last_grant_q;
    busy_d         = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (|reqValid) begin
          req_ready_d[grant_sel_c] = 1'b1;
          core_start_d             = 1'b1;
          core_enc_dec_d           = reqEncDec[grant_sel_c];
          core_block_d             = reqBlock[grant_sel_c];
          grant_id_d               = grant_sel_c;
        end
      end
      S_WAIT: begin
        if (coreDone) begin
          resp_block_d          = coreResult;
          resp_valid_d          = 2'b00;
          resp_valid_d[grantId] = 1'b1;
        end else if (wdog_hit_c) begin
          resp_block_d          = '0;
          resp_valid_d          = 2'b00;
          resp_valid_d[grantId] = 1'b1;
        end
      end
      S_RESP: begin
        if (respReady[grantId]) begin
          resp_valid_d = 2'b00;
          last_grant_d = grantId;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      reqReady     <= 2'b00;
      coreStart    <= 1'b0;
      coreEncDec   <= 1'b0;
      coreBlock    <= '0;
      grantId      <= 1'b0;
      respValid    <= 2'b00;
      respBlock    <= '0;
      busy         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      reqReady     <= req_ready_d;
      coreStart    <= core_start_d;
      coreEncDec   <= core_enc_dec_d;
      coreBlock    <= core_block_d;
      grantId      <= grant_id_d;
      respValid    <= resp_valid_d;
      respBlock    <= resp_block_d;
      busy         <= busy_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef SIMON_ARB_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TMAX - 1);

  logic [7:0] wdog_q;

  // Fires on the TMAX-th WAIT cycle; a coreDone at the same edge takes precedence.
  assign wdog_hit_c = (state_q == S_WAIT) && (wdog_q == WDOG_LAST);

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      wdog_q  <= 8'd0;
      respErr <= 1'b0;
    end else begin
      if (state_q == S_ISSUE)     wdog_q <= 8'd0;
      else if (state_q == S_WAIT) wdog_q <= wdog_q + 8'd1;

      if (wdog_hit_c && !coreDone)                      respErr <= 1'b1;
      else if (state_q == S_RESP && respReady[grantId]) respErr <= 1'b0;
    end
  end
`else
  logic unused_tmax;

  assign unused_tmax = ^32'(TMAX);
  assign wdog_hit_c  = 1'b0;
  assign respErr     = 1'b0;
`endif

endmodule

// File: tb/tb_simon_core_arbiter.sv
// Directed self-checking bench for simon_core_arbiter with a stub SIMON core.
// Define SIMON_ARB_TIMEOUT_EN to also exercise the watchdog (TMAX=8).
module tb_simon_core_arbiter;
  localparam int unsigned N  = 16;
  localparam int unsigned BW = 2 * N;

  logic                 clk = 1'b0;
  logic                 nR;
  logic [1:0]           req_valid, req_enc_dec, req_ready, resp_valid, resp_ready;
  logic [1:0][BW-1:0]   req_block;
  logic [BW-1:0]        resp_block, core_block, core_result;
  logic                 resp_err, core_start, core_enc_dec, core_done, busy, grant_id;

  int n_vec = 0;
  int n_err = 0;

  logic          stub_en   = 1'b0;
  int            stub_lat  = 4;
  logic          stub_done = 1'b0;
  logic [BW-1:0] stub_res  = '0;
  logic          man_done  = 1'b0;
  logic [BW-1:0] man_res   = '0;

  assign core_done   = stub_done | man_done;
  assign core_result = stub_done ? stub_res : man_res;

  always #5 clk = ~clk;

  simon_core_arbiter #(.N(N), .TMAX(8)) dut (
    .clk(clk), .nR(nR),
    .reqValid(req_valid), .reqEncDec(req_enc_dec), .reqBlock(req_block), .reqReady(req_ready),
    .respValid(resp_valid), .respReady(resp_ready), .respBlock(resp_block), .respErr(resp_err),
    .coreStart(core_start), .coreEncDec(core_enc_dec), .coreBlock(core_block),
    .coreDone(core_done), .coreResult(core_result), .busy(busy), .grantId(grant_id)
  );

  function automatic logic [BW-1:0] stub_fn(input logic [BW-1:0] b);
    return (b == 32'h6565_6877) ? 32'hC69B_E9BB : ~b;
  endfunction

  // Stub core: done pulses for one cycle stub_lat cycles after the start pulse.
  initial begin : stub_core
    logic [BW-1:0] blk;
    forever begin
      @(posedge clk); #2;
      if (stub_en && core_start) begin
        blk = core_block;
        repeat (stub_lat) @(posedge clk);
        #2; stub_done = 1'b1; stub_res = stub_fn(blk);
        @(posedge clk); #2; stub_done = 1'b0; stub_res = '0;
      end
    end
  end

  initial begin : global_guard
    #400000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic wait_resp(input int budget);
    int k = 0;
    while (resp_valid === 2'b00 && k < budget) begin @(negedge clk); k++; end
    if (resp_valid === 2'b00) begin
      n_vec++; n_err++;
      $display("FAIL wait_resp: respValid=%b after %0d cycles, required nonzero", resp_valid, budget);
    end
  endtask

  task automatic do_reset();
    nR = 1'b0; req_valid = 2'b00; resp_ready = 2'b00; man_done = 1'b0;
    repeat (2) @(negedge clk);
    nR = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    nR = 1'b0; req_valid = 2'b11; req_enc_dec = 2'b11; resp_ready = 2'b11;
    req_block[0] = 32'h1111_1111; req_block[1] = 32'h2222_2222;
    repeat (3) @(negedge clk);
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_reqReady: got %b expected 00", req_ready); end
    n_vec++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL rst_respValid: got %b expected 00", resp_valid); end
    n_vec++; if (resp_block !== 32'h0) begin n_err++; $display("FAIL rst_respBlock: got %h expected 0", resp_block); end
    n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_respErr: got %b expected 0", resp_err); end
    n_vec++; if (core_start !== 1'b0) begin n_err++; $display("FAIL rst_coreStart: got %b expected 0", core_start); end
    n_vec++; if (core_block !== 32'h0) begin n_err++; $display("FAIL rst_coreBlock: got %h expected 0", core_block); end
    n_vec++; if (core_enc_dec !== 1'b0) begin n_err++; $display("FAIL rst_coreEncDec: got %b expected 0", core_enc_dec); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_vec++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL rst_grantId: got %b expected 0", grant_id); end
    req_valid = 2'b00; resp_ready = 2'b00;
    nR = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_encrypt();
    int k;
    stub_en = 1'b1; stub_lat = 32;
    req_block[0] = 32'h6565_6877; req_enc_dec = 2'b01; req_valid = 2'b01;
    @(negedge clk);
    n_vec++; if ({req_ready, core_start} !== 3'b011) begin n_err++; $display("FAIL enc_issue: reqReady/coreStart got %b/%b expected 01/1", req_ready, core_start); end
    n_vec++; if ({core_block, core_enc_dec, busy, grant_id} !== {32'h6565_6877, 3'b110}) begin
      n_err++; $display("FAIL enc_capture: block/enc/busy/gnt got %h/%b/%b/%b expected 65656877/1/1/0", core_block, core_enc_dec, busy, grant_id); end
    req_valid = 2'b00;
    @(negedge clk);
    n_vec++; if ({req_ready, core_start} !== 3'b000) begin n_err++; $display("FAIL enc_pulse_end: reqReady/coreStart got %b/%b expected 00/0", req_ready, core_start); end
    k = 0;
    while (core_done !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    n_vec++; if (resp_valid !== 2'b00 || k != 31) begin n_err++; $display("FAIL enc_done_wait: respValid=%b wait=%0d expected 00 and 31", resp_valid, k); end
    @(negedge clk);
    n_vec++; if ({resp_valid, resp_block, resp_err} !== {2'b01, 32'hC69B_E9BB, 1'b0}) begin
      n_err++; $display("FAIL enc_resp: valid/block/err got %b/%h/%b expected 01/c69be9bb/0", resp_valid, resp_block, resp_err); end
    resp_ready = 2'b01;
    @(negedge clk);
    n_vec++; if ({busy, resp_valid} !== 3'b000) begin n_err++; $display("FAIL enc_idle: busy/respValid got %b/%b expected 0/00", busy, resp_valid); end
    resp_ready = 2'b00;
  endtask

  task automatic test_simultaneous();
    do_reset();
    stub_en = 1'b1; stub_lat = 4;
    req_block[0] = 32'h0000_0001; req_block[1] = 32'h0000_0002; req_enc_dec = 2'b10;
    req_valid = 2'b11;
    @(negedge clk);
    n_vec++; if ({req_ready, grant_id, core_block, core_enc_dec} !== {2'b01, 1'b0, 32'h1, 1'b0}) begin
      n_err++; $display("FAIL sim_first: rdy/gnt/block/enc got %b/%b/%h/%b expected 01/0/00000001/0", req_ready, grant_id, core_block, core_enc_dec); end
    req_valid = 2'b10;
    wait_resp(20);
    n_vec++; if ({resp_valid, resp_block} !== {2'b01, 32'hFFFF_FFFE}) begin
      n_err++; $display("FAIL sim_resp0: valid/block got %b/%h expected 01/fffffffe", resp_valid, resp_block); end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
    n_vec++; if ({busy, req_ready} !== 3'b000) begin n_err++; $display("FAIL sim_gap: busy/reqReady got %b/%b expected 0/00", busy, req_ready); end
    @(negedge clk);
    n_vec++; if ({req_ready, grant_id, core_block, core_enc_dec} !== {2'b10, 1'b1, 32'h2, 1'b1}) begin
      n_err++; $display("FAIL sim_second: rdy/gnt/block/enc got %b/%b/%h/%b expected 10/1/00000002/1", req_ready, grant_id, core_block, core_enc_dec); end
    req_valid = 2'b00;
    wait_resp(20);
    n_vec++; if ({resp_valid, resp_block} !== {2'b10, 32'hFFFF_FFFD}) begin
      n_err++; $display("FAIL sim_resp1: valid/block got %b/%h expected 10/fffffffd", resp_valid, resp_block); end
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = 2'b00;
  endtask

  task automatic test_contention();
    logic two_hot;
    int   k;
    stub_en = 1'b1; stub_lat = 3;
    req_block[0] = 32'h0A0A_0A0A; req_block[1] = 32'h0B0B_0B0B;
    two_hot = 1'b0;
    resp_ready = 2'b11; req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      k = 0;
      @(negedge clk);
      while (req_ready === 2'b00 && k < 30) begin
        if (resp_valid === 2'b11) two_hot = 1'b1;
        @(negedge clk); k++;
      end
      n_vec++; if (grant_id !== 1'(i % 2) || req_ready !== 2'(1 << (i % 2))) begin
        n_err++; $display("FAIL cont_grant%0d: gnt/rdy got %b/%b expected %0d/%b", i, grant_id, req_ready, i % 2, 2'(1 << (i % 2))); end
    end
    req_valid = 2'b00;
    k = 0;
    while (busy !== 1'b0 && k < 30) begin
      if (resp_valid === 2'b11) two_hot = 1'b1;
      @(negedge clk); k++;
    end
    n_vec++; if (two_hot !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL cont_onehot: two_hot/busy got %b/%b expected 0/0", two_hot, busy); end
    resp_ready = 2'b00;
  endtask

  task automatic test_back_to_back();
    stub_en = 1'b1; stub_lat = 2;
    req_block[0] = 32'h1234_5678; req_enc_dec = 2'b01; req_valid = 2'b01;
    @(negedge clk);
    req_block[1] = 32'hABCD_0000; req_valid = 2'b10;
    wait_resp(20);
    resp_ready = 2'b10;
    for (int c = 0; c < 10; c++) begin
      n_vec++; if ({resp_valid, resp_block, core_start, req_ready} !== {2'b01, 32'hEDCB_A987, 3'b000}) begin
        n_err++; $display("FAIL bp_hold%0d: valid/block/start/rdy got %b/%h/%b/%b expected 01/edcba987/0/00", c, resp_valid, resp_block, core_start, req_ready); end
      @(negedge clk);
    end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
    n_vec++; if ({busy, resp_valid, req_ready} !== 5'b0) begin n_err++; $display("FAIL bp_release: busy/valid/rdy got %b/%b/%b expected 0/00/00", busy, resp_valid, req_ready); end
    @(negedge clk);
    n_vec++; if ({req_ready, grant_id, core_block, core_enc_dec} !== {2'b10, 1'b1, 32'hABCD_0000, 1'b0}) begin
      n_err++; $display("FAIL bp_grant1: rdy/gnt/block/enc got %b/%b/%h/%b expected 10/1/abcd0000/0", req_ready, grant_id, core_block, core_enc_dec); end
    req_valid = 2'b00;
    wait_resp(20);
    n_vec++; if ({resp_valid, resp_block} !== {2'b10, 32'h5432_FFFF}) begin
      n_err++; $display("FAIL bp_resp1: valid/block got %b/%h expected 10/5432ffff", resp_valid, resp_block); end
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = 2'b00;
  endtask

  task automatic test_spurious_reset();
    stub_en = 1'b0;
    man_done = 1'b1; man_res = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++; if ({resp_valid, busy} !== 3'b000) begin n_err++; $display("FAIL spur_idle%0d: valid/busy got %b/%b expected 00/0", c, resp_valid, busy); end
    end
    man_done = 1'b0;
    // Serve requester 0 so that only a reset can restore requester 0's priority.
    stub_en = 1'b1; stub_lat = 2;
    req_block[0] = 32'h0000_0007; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    wait_resp(20);
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
    stub_en = 1'b0;
    req_block[1] = 32'h0000_0003; req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    nR = 1'b0;
    #1;
    n_vec++; if ({req_ready, resp_valid, resp_block, resp_err, core_start, core_block, core_enc_dec, busy, grant_id} !== '0) begin
      n_err++; $display("FAIL mid_reset: rdy/valid/rblk/err/start/cblk/enc/busy/gnt got %b/%b/%h/%b/%b/%h/%b/%b/%b expected all 0",
                        req_ready, resp_valid, resp_block, resp_err, core_start, core_block, core_enc_dec, busy, grant_id); end
    @(negedge clk);
    nR = 1'b1; man_done = 1'b1; man_res = 32'h0000_1234;
    @(negedge clk);
    man_done = 1'b0;
    n_vec++; if ({resp_valid, busy} !== 3'b000) begin n_err++; $display("FAIL late_done: valid/busy got %b/%b expected 00/0", resp_valid, busy); end
    req_block[0] = 32'h0000_0008; req_block[1] = 32'h0000_0009; req_valid = 2'b11;
    @(negedge clk);
    n_vec++; if ({req_ready, grant_id, core_block} !== {2'b01, 1'b0, 32'h8}) begin
      n_err++; $display("FAIL post_rst_grant: rdy/gnt/block got %b/%b/%h expected 01/0/00000008", req_ready, grant_id, core_block); end
    req_valid = 2'b00;
    @(negedge clk);
    man_done = 1'b1; man_res = 32'hAAAA_5555;
    @(negedge clk);
    man_done = 1'b0;
    n_vec++; if ({resp_valid, resp_block} !== {2'b01, 32'hAAAA_5555}) begin
      n_err++; $display("FAIL post_rst_resp: valid/block got %b/%h expected 01/aaaa5555", resp_valid, resp_block); end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
  endtask

`ifdef SIMON_ARB_TIMEOUT_EN
  task automatic test_timeout();
    stub_en = 1'b0;
    for (int t = 0; t < 2; t++) begin
      req_block[0] = 32'h0000_0005; req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      repeat (7) @(negedge clk);
      n_vec++; if ({resp_valid, busy} !== 3'b001) begin n_err++; $display("FAIL to_wait8_%0d: valid/busy got %b/%b expected 00/1", t, resp_valid, busy); end
      if (t == 1) begin man_done = 1'b1; man_res = 32'h1111_2222; end
      @(negedge clk);
      man_done = 1'b0;
      if (t == 0) begin
        n_vec++; if ({resp_valid, resp_err, resp_block} !== {2'b01, 1'b1, 32'h0}) begin
          n_err++; $display("FAIL to_abort: valid/err/block got %b/%b/%h expected 01/1/00000000", resp_valid, resp_err, resp_block); end
      end else begin
        n_vec++; if ({resp_valid, resp_err, resp_block} !== {2'b01, 1'b0, 32'h1111_2222}) begin
          n_err++; $display("FAIL to_done_wins: valid/err/block got %b/%b/%h expected 01/0/11112222", resp_valid, resp_err, resp_block); end
      end
      resp_ready = 2'b01;
      @(negedge clk);
      resp_ready = 2'b00;
      n_vec++; if ({resp_valid, resp_err} !== 3'b000) begin n_err++; $display("FAIL to_clear%0d: valid/err got %b/%b expected 00/0", t, resp_valid, resp_err); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_encrypt();
    test_simultaneous();
    test_contention();
    test_back_to_back();
    test_spurious_reset();
`ifdef SIMON_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
